seq_frame_tx: RTL and testbench

//  Serial frame transmitter. Its bit stream is what the 0101 Mealy sequence detector receives.

---
 rtl/seq_frame_tx_if.sv | 11 +
 rtl/seq_frame_tx.sv | 168 ++++++++++++++++
 tb/tb_seq_frame_tx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_frame_tx_if.sv
// Parallel word handshake into the serial frame transmitter.
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble then MSB-first payload, with a stuff 0
// inserted after any data bit that leaves the last three line bits at 010, so
// a downstream 0101 detector fires only on the preamble. Line idles at 1.
module seq_frame_tx #(
  parameter int         DATA_W       = 8,
  parameter int         CLKS_PER_BIT = 1,
  parameter logic [3:0] PREAMBLE     = 4'b0101
) (
  input  logic           clk,
  input  logic           rst,
  seq_frame_tx_if.slave  s_if,
  output logic           out,
  output logic           out_en,
  output logic           busy,
  output logic           frame_done
);

  localparam int CLK_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_MAX = (DATA_W > 4) ? DATA_W : 4;
  localparam int IDX_W   = $clog2(IDX_MAX);

  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] PRE_MSB  = IDX_W'(3);
  localparam logic [IDX_W-1:0] DATA_MSB = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, PRE, DATA, STUFF} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;          // payload, shifted out from the MSB
  logic [IDX_W-1:0]  idx_q, idx_d;            // preamble index / data bits still to send
  logic [CLK_W-1:0]  clk_cnt_q, clk_cnt_d;    // cycles elapsed in the current bit
  logic [2:0]        hist_q, hist_d;          // last three bits driven on the line
  logic              out_q, out_d;
  logic              out_en_q, out_en_d;
  logic              in_ready_q, in_ready_d;
  logic              frame_done_q, frame_done_d;

  logic              period_end;
  logic [IDX_W-1:0]  idx_dec;
  logic              emit;
  logic              next_bit;
  logic              finish;

  assign period_end = (clk_cnt_q == CLK_LAST);
  assign idx_dec    = idx_q - IDX_W'(1);

  // Next-state logic: bit sequencing, stuffing decision and handshake.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would infer a latch.
    state_d      = state_q;
    data_d       = data_q;
    idx_d        = idx_q;
    clk_cnt_d    = clk_cnt_q;
    hist_d       = hist_q;
    out_d        = out_q;
    out_en_d     = out_en_q;
    in_ready_d   = in_ready_q;
    frame_done_d = 1'b0;
    emit         = 1'b0;
    next_bit     = 1'b1;
    finish       = 1'b0;

    if (state_q == IDLE) begin
      clk_cnt_d = '0;
      if (s_if.in_valid && in_ready_q) begin
        data_d     = s_if.in_data;
        state_d    = PRE;
        idx_d      = PRE_MSB;
        in_ready_d = 1'b0;
        out_en_d   = 1'b1;
        emit       = 1'b1;
        next_bit   = PREAMBLE[3];
      end
    end else if (!period_end) begin
      clk_cnt_d = clk_cnt_q + CLK_W'(1);
    end else begin
      clk_cnt_d = '0;
      case (state_q)
        PRE: begin
          emit = 1'b1;
          if (idx_q != '0) begin
            idx_d    = idx_dec;
            next_bit = PREAMBLE[idx_dec[1:0]];
          end else begin
            // Preamble bits never trigger stuffing; go straight to the payload.
            state_d  = DATA;
            idx_d    = DATA_MSB;
            next_bit = data_q[DATA_W-1];
            data_d   = data_q << 1;
          end
        end
        DATA: begin
          if (hist_q == 3'b010) begin
            state_d  = STUFF;
            emit     = 1'b1;
            next_bit = 1'b0;
          end else if (idx_q != '0) begin
            idx_d    = idx_dec;
            emit     = 1'b1;
            next_bit = data_q[DATA_W-1];
            data_d   = data_q << 1;
          end else begin
            finish = 1'b1;
          end
        end
        STUFF: begin
          if (idx_q != '0) begin
            state_d  = DATA;
            idx_d    = idx_dec;
            emit     = 1'b1;
            next_bit = data_q[DATA_W-1];
            data_d   = data_q << 1;
          end else begin
            finish = 1'b1;
          end
        end
        default: finish = 1'b1;
      endcase
    end

    if (emit) begin
      out_d  = next_bit;
      hist_d = {hist_q[1:0], next_bit};
    end

    if (finish) begin
      state_d      = IDLE;
      out_d        = 1'b1;
      out_en_d     = 1'b0;
      in_ready_d   = 1'b1;
      frame_done_d = 1'b1;
    end
  end

  // State register; asynchronous reset returns the line to idle immediately.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    if (!rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      idx_q        <= '0;
      clk_cnt_q    <= '0;
      hist_q       <= 3'b111;
      out_q        <= 1'b1;
      out_en_q     <= 1'b0;
      in_ready_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      idx_q        <= idx_d;
      clk_cnt_q    <= clk_cnt_d;
      hist_q       <= hist_d;
      out_q        <= out_d;
      out_en_q     <= out_en_d;
      in_ready_q   <= in_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s_if.in_ready = in_ready_q;
  assign out           = out_q;
  assign out_en        = out_en_q;
  assign busy          = ~in_ready_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Randomized self-checking bench for seq_frame_tx: one instance at one clk per
// bit, one at three clks per bit, compared against a frame-building model.
module tb_seq_frame_tx;

  localparam logic [3:0] PRE = 4'b0101;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_frame_tx_if #(.DATA_W(8)) if1 ();
  seq_frame_tx_if #(.DATA_W(8)) if3 ();

  logic out1, en1, busy1, fd1;
  logic out3, en3, busy3, fd3;

  seq_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PREAMBLE(PRE)) dut1 (
    .clk(clk), .rst(rst), .s_if(if1),
    .out(out1), .out_en(en1), .busy(busy1), .frame_done(fd1)
  );

  seq_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(3), .PREAMBLE(PRE)) dut3 (
    .clk(clk), .rst(rst), .s_if(if3),
    .out(out3), .out_en(en3), .busy(busy3), .frame_done(fd3)
  );

  int   sel = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic o_out, o_en, o_rdy, o_busy, o_fd;

  always_comb begin
    o_out  = (sel == 0) ? out1  : out3;
    o_en   = (sel == 0) ? en1   : en3;
    o_busy = (sel == 0) ? busy1 : busy3;
    o_fd   = (sel == 0) ? fd1   : fd3;
    o_rdy  = (sel == 0) ? if1.in_ready : if3.in_ready;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic valid, input logic [7:0] data);
    if (sel == 0) begin
      if1.in_valid = valid;
      if1.in_data  = data;
    end else begin
      if3.in_valid = valid;
      if3.in_data  = data;
    end
  endtask

  // Expected line bits of one frame, oldest bit in the highest used position.
  function automatic int ref_frame(input logic [7:0] word, output logic [31:0] vec);
    int len = 0;
    vec = '0;
    for (int i = 3; i >= 0; i--) begin
      vec = {vec[30:0], PRE[i]};
      len++;
    end
    for (int i = 7; i >= 0; i--) begin
      vec = {vec[30:0], word[i]};
      len++;
      if (vec[2:0] == 3'b010) begin
        vec = {vec[30:0], 1'b0};
        len++;
      end
    end
    return len;
  endfunction

  // Reference 0101 detector over a frame preceded by idle 1s: count*256 + last hit index.
  function automatic int detect(input logic [31:0] vec, input int len_in);
    logic [3:0] win = 4'b1111;
    int cnt = 0;
    int pos = 0;
    int len = (len_in > 32) ? 32 : len_in;
    for (int k = 0; k < len; k++) begin
      win = {win[2:0], vec[len-1-k]};
      if (win == 4'b0101) begin
        cnt++;
        pos = k;
      end
    end
    return cnt * 256 + pos;
  endfunction

  // Waits (bounded) for in_ready at a falling edge, then offers one word for one edge.
  task automatic send(input logic [7:0] word);
    int guard = 0;
    while (!o_rdy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("ready_timeout", {31'd0, o_rdy}, 32'd1);
    drive(1'b1, word);
    @(negedge clk);
    drive(1'b0, 8'($urandom));
  endtask

  // Records the line while out_en is high and compares it with the model.
  task automatic capture(input logic [7:0] word, input bit poke);
    int          cpb = (sel == 0) ? 1 : 3;
    logic [31:0] exp_vec;
    logic [31:0] got_vec = '0;
    int          exp_len;
    int          raw_len = 0;
    int          hold_err = 0;
    logic        cur = 1'b1;
    exp_len = ref_frame(word, exp_vec);
    while (o_en && raw_len < 200) begin
      if (raw_len % cpb == 0) begin
        cur     = o_out;
        got_vec = {got_vec[30:0], cur};
      end else if (o_out !== cur) begin
        hold_err++;
      end
      if (o_rdy !== 1'b0 || o_busy !== 1'b1 || o_fd !== 1'b0) hold_err++;
      if (poke) drive(raw_len == 5, 8'($urandom));
      raw_len++;
      @(negedge clk);
    end
    check("frame_len", raw_len, exp_len * cpb);
    check("frame_bits", got_vec, exp_vec);
    check("bit_hold", hold_err, 0);
    check("detector", detect(got_vec, raw_len / cpb), 32'd259);
    check("frame_end", {o_fd, o_rdy, o_busy, o_en, o_out}, 5'b11001);
  endtask

  task automatic idle(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ({o_fd, o_rdy, o_busy, o_en, o_out} !== 5'b01001) bad++;
    end
    check("idle", bad, 0);
  endtask

  initial begin
    logic [7:0] w;
    if1.in_valid = 1'b0; if1.in_data = '0;
    if3.in_valid = 1'b0; if3.in_data = '0;

    // Reset state, then a long quiet idle.
    @(negedge clk);
    check("reset_state", {fd1, if1.in_ready, busy1, en1, out1}, 5'b01001);
    check("reset_state3", {fd3, if3.in_ready, busy3, en3, out3}, 5'b01001);
    rst = 1'b1;
    idle(20);

    // Directed frames: no stuffing, heavy stuffing, trailing stuff + back-to-back.
    sel = 0;
    send(8'hFF); capture(8'hFF, 1'b0); idle(3);
    send(8'h55); capture(8'h55, 1'b0); idle(2);
    send(8'hFA); capture(8'hFA, 1'b0);
    send(8'h40); capture(8'h40, 1'b0); idle(2);

    // Random words, random gaps (including back-to-back), random mid-frame pokes.
    for (int i = 0; i < 24; i++) begin
      w = 8'($urandom);
      send(w);
      capture(w, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 4));
    end

    // Three clocks per bit, with a mid-frame in_valid that must be ignored.
    sel = 1;
    send(8'hFF); capture(8'hFF, 1'b1); idle(2);
    for (int i = 0; i < 4; i++) begin
      w = 8'($urandom);
      send(w);
      capture(w, 1'b1);
      if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 3));
    end

    // Asynchronous reset during bit 6 of a frame, then a clean frame.
    sel = 0;
    idle(1);
    send(8'hA7);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset", {fd1, if1.in_ready, busy1, en1, out1}, 5'b01001);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    w = 8'($urandom);
    send(w);
    capture(w, 1'b0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
